// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage / hazard-controller bundle: decoded ID operands and redirect in,
// stall/issue/flush decisions, forwarding selects and status out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned SEL_W = $clog2(DEPTH);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_regwrite;
  logic              id_is_load;
  logic [REG_AW-1:0] id_rd;
  logic              redirect;

  logic              stall;
  logic              issue;
  logic              flush_ifid;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;
  logic [DEPTH-1:0]  stage_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_regwrite, id_is_load, id_rd, redirect,
    input  stall, issue, flush_ifid, fwd_rs_sel, fwd_rt_sel,
           stage_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_regwrite, id_is_load, id_rd, redirect,
    output stall, issue, flush_ifid, fwd_rs_sel, fwd_rt_sel,
           stage_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the WISC-S15 pipeline: tracks
// issued instructions through a DEPTH-stage back-end and decides stall/issue.
module pipe_hazard_ctrl #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned REG_AW     = 4,
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(DEPTH);
  // The last stage writes through the regfile, so only the first DEPTH-1
  // stages need the producer fields; the valid bit is kept for all stages.
  localparam int unsigned NT = DEPTH - 1;

  logic [DEPTH-1:0]           v_q, v_d;
  logic [NT-1:0]              wr_q, wr_d;
  logic [NT-1:0]              ld_q, ld_d;
  logic [NT-1:0][REG_AW-1:0]  rd_q, rd_d;
  logic [SEL_W-1:0]           rs_sel_q, rs_sel_d;
  logic [SEL_W-1:0]           rt_sel_q, rt_sel_d;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]           flush_cnt_q, flush_cnt_d;

  logic [NT-1:0]              m_rs, m_rt;
  logic                       rs_hit, rt_hit;
  logic                       rs_ld_hz, rt_ld_hz;
  logic [SEL_W-1:0]           rs_sel, rt_sel;
  logic                       stall_raw;
  logic                       stall;
  logic                       issue;

  always_comb begin
    m_rs = '0;
    m_rt = '0;
    for (int unsigned k = 0; k < NT; k++) begin
      m_rs[k] = v_q[k] & wr_q[k] & (rd_q[k] != '0) & (rd_q[k] == bus.id_rs) & bus.id_rs_used;
      m_rt[k] = v_q[k] & wr_q[k] & (rd_q[k] != '0) & (rd_q[k] == bus.id_rt) & bus.id_rt_used;
    end
  end

  // Youngest producer per source wins; a load is only a hazard while its data
  // has not yet reached the stage it can be forwarded from.
  always_comb begin
    rs_hit   = 1'b0;
    rt_hit   = 1'b0;
    rs_ld_hz = 1'b0;
    rt_ld_hz = 1'b0;
    rs_sel   = '0;
    rt_sel   = '0;
    for (int unsigned k = 0; k < NT; k++) begin
      if (!rs_hit && m_rs[k]) begin
        rs_hit   = 1'b1;
        rs_sel   = SEL_W'(k + 1);
        rs_ld_hz = ld_q[k] && (k + 1 < LOAD_STAGE);
      end
      if (!rt_hit && m_rt[k]) begin
        rt_hit   = 1'b1;
        rt_sel   = SEL_W'(k + 1);
        rt_ld_hz = ld_q[k] && (k + 1 < LOAD_STAGE);
      end
    end
  end

  always_comb begin
    stall_raw = FWD_EN ? (rs_ld_hz | rt_ld_hz) : (rs_hit | rt_hit);
    stall     = bus.id_valid & stall_raw & ~bus.redirect;
    issue     = bus.id_valid & ~stall & ~bus.redirect;
  end

  always_comb begin
    v_d  = {v_q[DEPTH-2:0], issue};
    wr_d = wr_q;
    ld_d = ld_q;
    rd_d = rd_q;
    wr_d[0] = bus.id_regwrite & issue;
    ld_d[0] = bus.id_is_load & issue;
    rd_d[0] = bus.id_rd;
    for (int unsigned k = 1; k < NT; k++) begin
      wr_d[k] = wr_q[k-1];
      ld_d[k] = ld_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
  end

  always_comb begin
    rs_sel_d = (issue && FWD_EN) ? rs_sel : '0;
    rt_sel_d = (issue && FWD_EN) ? rt_sel : '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (bus.redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q         <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      rd_q        <= '0;
      rs_sel_q    <= '0;
      rt_sel_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      wr_q        <= wr_d;
      ld_q        <= ld_d;
      rd_q        <= rd_d;
      rs_sel_q    <= rs_sel_d;
      rt_sel_q    <= rt_sel_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.issue       = issue;
  assign bus.flush_ifid  = bus.redirect;
  assign bus.fwd_rs_sel  = rs_sel_q;
  assign bus.fwd_rt_sel  = rt_sel_q;
  assign bus.stage_valid = v_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
endmodule
